stream_flush_ctrl: RTL and testbench

STREAM_FLUSH_CTRL -- requirements
Module: stream_flush_ctrl

---
 rtl/stream_flush_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_stream_flush_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_flush_ctrl.sv
// Stream flush controller.
// Passes an upstream stream into a flushable downstream buffer, tracks how many
// entries the buffer holds, and runs a 4-phase flush handshake. A flush may
// first try to drain the buffer gracefully, bounded by a cycle timeout. The
// controller reports how many entries the flush discarded and whether the
// drain attempt timed out.

module stream_flush_ctrl_chk #(
    parameter int unsigned Depth = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_o,
    input  logic                           flush_ack_o,
    input  logic                           out_valid_o,
    input  logic [$clog2(Depth + 1)-1:0]   inflight_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [CntW-1:0] DepthC = CntW'(Depth);

    // A flush must never coincide with a new entry entering the buffer.
    a_no_flush_with_push : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(flush_o && out_valid_o));

    // The occupancy counter never exceeds the buffer capacity.
    a_inflight_bounded : assert property (@(posedge clk_i) disable iff (!rst_ni)
        inflight_o <= DepthC);

    // Every flush strobe is followed by the acknowledge on the next cycle.
    a_ack_after_flush : assert property (@(posedge clk_i) disable iff (!rst_ni)
        flush_o |=> flush_ack_o);

endmodule

module stream_flush_ctrl #(
    parameter type         T             = logic,
    parameter int unsigned Depth         = 2,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_req_i,
    input  logic                           drain_i,
    output logic                           flush_ack_o,
    output logic [$clog2(Depth + 1)-1:0]   dropped_o,
    output logic                           timeout_o,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  T                               in_data_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output T                               out_data_o,
    output logic                           flush_o,
    input  logic                           buf_valid_i,
    input  logic                           buf_ready_i,
    output logic [$clog2(Depth + 1)-1:0]   inflight_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
    localparam logic [7:0]      TmoLast = 8'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    state_e            state_r;
    state_e            state_nxt_s;
    logic [CntW-1:0]   inflight_r;
    logic [CntW-1:0]   inflight_nxt_s;
    logic [7:0]        timer_r;
    logic [7:0]        timer_nxt_s;
    logic [CntW-1:0]   dropped_r;
    logic              timeout_r;
    logic              timeout_nxt_s;
    logic              flush_r;
    logic              ack_r;
    logic              open_s;
    logic              push_s;
    logic              pop_s;

    // Stream pass-through: open only in IDLE while no flush is being requested.
    always_comb begin
        open_s      = (state_r == ST_IDLE) && !flush_req_i;
        out_data_o  = in_data_i;
        out_valid_o = in_valid_i && open_s;
        in_ready_o  = out_ready_i && open_s;
        push_s      = in_valid_i && out_ready_i && open_s;
        pop_s       = buf_valid_i && buf_ready_i;
    end

    // Next occupancy: saturating up/down counter, cleared by a flush.
    always_comb begin
        inflight_nxt_s = inflight_r;
        if (state_r == ST_FLUSH) begin
            inflight_nxt_s = {CntW{1'b0}};
        end else if (push_s && !pop_s) begin
            if (inflight_r != DepthC) begin
                inflight_nxt_s = inflight_r + {{(CntW-1){1'b0}}, 1'b1};
            end else begin
                inflight_nxt_s = inflight_r;
            end
        end else if (pop_s && !push_s) begin
            if (inflight_r != {CntW{1'b0}}) begin
                inflight_nxt_s = inflight_r - {{(CntW-1){1'b0}}, 1'b1};
            end else begin
                inflight_nxt_s = inflight_r;
            end
        end else begin
            inflight_nxt_s = inflight_r;
        end
    end

    // Drain timer: zero outside DRAIN, counts cycles spent in DRAIN.
    always_comb begin
        timer_nxt_s = 8'd0;
        if (state_r == ST_DRAIN) begin
            timer_nxt_s = timer_r + 8'd1;
        end else begin
            timer_nxt_s = 8'd0;
        end
    end

    // Flush sequencer next state; the timeout flag is decided on entry to FLUSH.
    always_comb begin
        state_nxt_s   = state_r;
        timeout_nxt_s = timeout_r;
        case (state_r)
            ST_IDLE: begin
                if (flush_req_i) begin
                    if (drain_i) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s   = ST_FLUSH;
                        timeout_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Exit as soon as the last buffered entry leaves this cycle.
                if (inflight_nxt_s == {CntW{1'b0}}) begin
                    state_nxt_s   = ST_FLUSH;
                    timeout_nxt_s = 1'b0;
                end else if (timer_r == TmoLast) begin
                    state_nxt_s   = ST_FLUSH;
                    timeout_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                state_nxt_s = ST_ACK;
            end
            ST_ACK: begin
                if (!flush_req_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACK;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and status registers; flush/ack strobes are registered decodes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_IDLE;
            inflight_r <= {CntW{1'b0}};
            timer_r    <= 8'd0;
            dropped_r  <= {CntW{1'b0}};
            timeout_r  <= 1'b0;
            flush_r    <= 1'b0;
            ack_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            inflight_r <= inflight_nxt_s;
            timer_r    <= timer_nxt_s;
            timeout_r  <= timeout_nxt_s;
            flush_r    <= (state_nxt_s == ST_FLUSH);
            ack_r      <= (state_nxt_s == ST_ACK);
            if (state_r == ST_FLUSH) begin
                dropped_r <= inflight_r;
            end else begin
                dropped_r <= dropped_r;
            end
        end
    end

    assign flush_o     = flush_r;
    assign flush_ack_o = ack_r;
    assign dropped_o   = dropped_r;
    assign timeout_o   = timeout_r;
    assign inflight_o  = inflight_r;

    stream_flush_ctrl_chk #(
        .Depth (Depth)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_o     (flush_o),
        .flush_ack_o (flush_ack_o),
        .out_valid_o (out_valid_o),
        .inflight_o  (inflight_o)
    );

endmodule

// File: tb/tb_stream_flush_ctrl.sv
// Directed testbench for stream_flush_ctrl (Depth=2, TimeoutCycles=16, 8-bit payload).

module tb_stream_flush_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       flush_req_i;
    logic       drain_i;
    logic       flush_ack_o;
    logic [1:0] dropped_o;
    logic       timeout_o;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] in_data_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [7:0] out_data_o;
    logic       flush_o;
    logic       buf_valid_i;
    logic       buf_ready_i;
    logic [1:0] inflight_o;

    int checks = 0;
    int errors = 0;

    stream_flush_ctrl #(
        .T             (logic [7:0]),
        .Depth         (2),
        .TimeoutCycles (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_req_i (flush_req_i),
        .drain_i     (drain_i),
        .flush_ack_o (flush_ack_o),
        .dropped_o   (dropped_o),
        .timeout_o   (timeout_o),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .flush_o     (flush_o),
        .buf_valid_i (buf_valid_i),
        .buf_ready_i (buf_ready_i),
        .inflight_o  (inflight_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; flush_req_i = 1'b0; drain_i = 1'b0;
        in_valid_i = 1'b0; in_data_i = 8'h00; out_ready_i = 1'b1;
        buf_valid_i = 1'b0; buf_ready_i = 1'b0;
        #12;
        checks++; if ({flush_o, flush_ack_o, timeout_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {flush_o, flush_ack_o, timeout_o}); end
        checks++; if ({dropped_o, inflight_o} !== 4'b0000) begin errors++; $display("FAIL reset_counts: got %b expected 0000", {dropped_o, inflight_o}); end
        checks++; if ({out_valid_o, in_ready_o} !== 2'b01) begin errors++; $display("FAIL reset_stream: got %b expected 01", {out_valid_o, in_ready_o}); end
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_passthrough();
        in_valid_i = 1'b1; in_data_i = 8'hA5; out_ready_i = 1'b0;
        #1;
        checks++; if ({out_valid_o, in_ready_o} !== 2'b10) begin errors++; $display("FAIL pass_handshake: got %b expected 10", {out_valid_o, in_ready_o}); end
        checks++; if (out_data_o !== 8'hA5) begin errors++; $display("FAIL pass_data: got %h expected a5", out_data_o); end
        step();
        checks++; if (inflight_o !== 2'd0) begin errors++; $display("FAIL pass_no_push: got %0d expected 0", inflight_o); end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
    endtask

    task automatic test_stream_flush();
        in_valid_i = 1'b1; in_data_i = 8'h11;
        step();
        in_data_i = 8'h22;
        step();
        checks++; if (inflight_o !== 2'd2) begin errors++; $display("FAIL sf_inflight: got %0d expected 2", inflight_o); end
        in_valid_i = 1'b0; flush_req_i = 1'b1; drain_i = 1'b0;
        step();
        checks++; if ({flush_o, flush_ack_o} !== 2'b10) begin errors++; $display("FAIL sf_flush_strobe: got %b expected 10", {flush_o, flush_ack_o}); end
        step();
        checks++; if ({flush_o, flush_ack_o} !== 2'b01) begin errors++; $display("FAIL sf_ack: got %b expected 01", {flush_o, flush_ack_o}); end
        checks++; if (dropped_o !== 2'd2) begin errors++; $display("FAIL sf_dropped: got %0d expected 2", dropped_o); end
        checks++; if ({inflight_o, timeout_o} !== 3'b000) begin errors++; $display("FAIL sf_clear: got %b expected 000", {inflight_o, timeout_o}); end
        step();
        checks++; if (flush_ack_o !== 1'b1) begin errors++; $display("FAIL sf_ack_hold: got %b expected 1", flush_ack_o); end
        flush_req_i = 1'b0;
        step();
        checks++; if (flush_ack_o !== 1'b0) begin errors++; $display("FAIL sf_ack_release: got %b expected 0", flush_ack_o); end
    endtask

    task automatic test_drain();
        in_valid_i = 1'b1;
        step();
        step();
        in_valid_i = 1'b0; flush_req_i = 1'b1; drain_i = 1'b1;
        step();
        buf_valid_i = 1'b1; buf_ready_i = 1'b1;
        checks++; if ({flush_o, inflight_o} !== 3'b010) begin errors++; $display("FAIL dr_cycle1: got %b expected 010", {flush_o, inflight_o}); end
        step();
        checks++; if ({flush_o, inflight_o} !== 3'b001) begin errors++; $display("FAIL dr_cycle2: got %b expected 001", {flush_o, inflight_o}); end
        step();
        buf_valid_i = 1'b0; buf_ready_i = 1'b0;
        checks++; if ({flush_o, inflight_o} !== 3'b100) begin errors++; $display("FAIL dr_cycle3_flush: got %b expected 100", {flush_o, inflight_o}); end
        step();
        checks++; if ({flush_ack_o, dropped_o, timeout_o} !== 4'b1000) begin errors++; $display("FAIL dr_result: got %b expected 1000", {flush_ack_o, dropped_o, timeout_o}); end
        flush_req_i = 1'b0; drain_i = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0; flush_req_i = 1'b1; drain_i = 1'b1;
        buf_valid_i = 1'b1; buf_ready_i = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (flush_o !== 1'b0) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL to_early_flush: got %0d early cycles expected 0", early); end
        step();
        checks++; if ({flush_o, flush_ack_o} !== 2'b10) begin errors++; $display("FAIL to_flush_cycle17: got %b expected 10", {flush_o, flush_ack_o}); end
        step();
        checks++; if ({flush_ack_o, dropped_o, timeout_o} !== 4'b1011) begin errors++; $display("FAIL to_result: got %b expected 1011", {flush_ack_o, dropped_o, timeout_o}); end
        flush_req_i = 1'b0; drain_i = 1'b0; buf_valid_i = 1'b0;
        step();
        step();
        checks++; if ({dropped_o, timeout_o} !== 3'b011) begin errors++; $display("FAIL to_status_hold: got %b expected 011", {dropped_o, timeout_o}); end
    endtask

    task automatic test_saturate();
        buf_valid_i = 1'b1; buf_ready_i = 1'b1;
        step();
        checks++; if (inflight_o !== 2'd0) begin errors++; $display("FAIL sat_floor: got %0d expected 0", inflight_o); end
        buf_valid_i = 1'b0;
        in_valid_i = 1'b1;
        step();
        buf_valid_i = 1'b1;
        step();
        checks++; if (inflight_o !== 2'd1) begin errors++; $display("FAIL sat_simul: got %0d expected 1", inflight_o); end
        buf_valid_i = 1'b0; buf_ready_i = 1'b0;
        step();
        step();
        checks++; if (inflight_o !== 2'd2) begin errors++; $display("FAIL sat_ceiling: got %0d expected 2", inflight_o); end
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        int pulses;
        pulses = 0;
        flush_req_i = 1'b1; drain_i = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (flush_o !== 1'b0) pulses++;
        end
        rst_ni = 1'b0;
        #1;
        checks++; if ({flush_o, flush_ack_o, timeout_o, dropped_o, inflight_o} !== 7'b0000000) begin errors++; $display("FAIL rst_outputs: got %b expected 0000000", {flush_o, flush_ack_o, timeout_o, dropped_o, inflight_o}); end
        for (int c = 0; c < 3; c++) begin
            step();
            if (flush_o !== 1'b0) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_no_pulse: got %0d pulses expected 0", pulses); end
        rst_ni = 1'b1;
        step();
        checks++; if ({flush_o, out_valid_o} !== 2'b00) begin errors++; $display("FAIL rst_restart_drain: got %b expected 00", {flush_o, out_valid_o}); end
        step();
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL rst_restart_flush: got %b expected 1", flush_o); end
        step();
        checks++; if ({flush_ack_o, dropped_o} !== 3'b100) begin errors++; $display("FAIL rst_restart_ack: got %b expected 100", {flush_ack_o, dropped_o}); end
        flush_req_i = 1'b0; drain_i = 1'b0;
        step();
    endtask

    task automatic test_gating();
        int leaks;
        int overlaps;
        leaks = 0; overlaps = 0;
        in_valid_i = 1'b1; in_data_i = 8'h5A; out_ready_i = 1'b1;
        #1;
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL gate_open: got %b expected 1", out_valid_o); end
        flush_req_i = 1'b1; drain_i = 1'b0;
        #1;
        checks++; if ({out_valid_o, in_ready_o} !== 2'b00) begin errors++; $display("FAIL gate_req_cycle: got %b expected 00", {out_valid_o, in_ready_o}); end
        for (int c = 0; c < 3; c++) begin
            step();
            if ((out_valid_o !== 1'b0) || (in_ready_o !== 1'b0)) leaks++;
            if (flush_o && out_valid_o) overlaps++;
        end
        flush_req_i = 1'b0;
        #1;
        if ((out_valid_o !== 1'b0) || (in_ready_o !== 1'b0)) leaks++;
        checks++; if (leaks !== 0) begin errors++; $display("FAIL gate_closed: got %0d open cycles expected 0", leaks); end
        checks++; if (overlaps !== 0) begin errors++; $display("FAIL gate_overlap: got %0d expected 0", overlaps); end
        step();
        checks++; if ({out_valid_o, in_ready_o, inflight_o} !== 4'b1100) begin errors++; $display("FAIL gate_reopen: got %b expected 1100", {out_valid_o, in_ready_o, inflight_o}); end
        in_valid_i = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_stream_flush();
        test_drain();
        test_timeout();
        test_saturate();
        test_reset_mid_drain();
        test_gating();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
